// File: rtl/seven_seg_scanner_if.sv
// Bundle of the pattern/control inputs and display outputs of the
// two-digit seven-segment scanner. The master side drives patterns and
// controls; the slave side (the scanner) drives the segment and digit
// buses.
interface seven_seg_scanner_if;
    logic [7:0] SevenSegDig1;
    logic [7:0] SevenSegDig2;
    logic       Load;
    logic       Enable;
    logic [2:0] Brightness;
    logic       BlankZero;
    logic [7:0] Segments;
    logic [1:0] DigitSel;
    logic       FrameDone;

    modport master (
        output SevenSegDig1, SevenSegDig2, Load, Enable, Brightness, BlankZero,
        input  Segments, DigitSel, FrameDone
    );

    modport slave (
        input  SevenSegDig1, SevenSegDig2, Load, Enable, Brightness, BlankZero,
        output Segments, DigitSel, FrameDone
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Two-digit multiplexed seven-segment scanner.
// Patterns are double-buffered (pending/active) so a new pattern only
// reaches the display at a frame start. Each digit gets TICK_DIV clocks,
// of which the first (Brightness+1)/8 are lit. Outputs are registered and
// are computed from the next-cycle state, so the visible timing matches a
// decode of the current state while no input reaches an output port
// without passing through a flop.
module seven_seg_scanner #(
    parameter int TICK_DIV = 16
) (
    input  logic Clk,
    input  logic Rst,
    seven_seg_scanner_if.slave bus
);

    localparam int CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SLOT = TICK_DIV / 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0]    PAT_ZERO = 8'b0011_1111;

    // Elaboration-time guard on the slot length.
    if ((TICK_DIV < 8) || ((TICK_DIV % 8) != 0)) begin : g_bad_tick_div
        $error("seven_seg_scanner: TICK_DIV must be a multiple of 8 and at least 8");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SCAN_D1 = 2'b01,
        SCAN_D2 = 2'b10
    } state_t;

    // True while the slot counter is inside the lit part of the slot.
    function automatic logic in_window(input logic [CW-1:0] cnt,
                                       input logic [2:0]    br);
        logic [CW+3:0] lim;
        lim = ((CW+4)'(br) + (CW+4)'(1'b1)) * (CW+4)'(SLOT);
        return ((CW+4)'(cnt) < lim);
    endfunction

    // True when digit 1 must be suppressed as a leading zero.
    function automatic logic blank_digit1(input logic [7:0] pat,
                                          input logic       bz);
        return bz && (pat == PAT_ZERO);
    endfunction

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nx_s;
    // Pattern sets are packed as {Dig1, Dig2}.
    logic [15:0]   pend_r;
    logic [15:0]   pend_nx_s;
    logic [15:0]   act_r;
    logic [15:0]   act_nx_s;
    logic [15:0]   load_pat_s;
    logic          frame_end_s;

    logic [7:0]    segments_r;
    logic [1:0]    digit_sel_r;
    logic          frame_done_r;
    logic [7:0]    segments_nx_s;
    logic [1:0]    digit_sel_nx_s;
    logic          frame_done_nx_s;

    assign load_pat_s  = {bus.SevenSegDig1, bus.SevenSegDig2};
    assign frame_end_s = (state_r == SCAN_D2) && (count_r == CNT_LAST);

    // Next scan state and slot counter.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        case (state_r)
            IDLE: begin
                count_nx_s = '0;
                if (bus.Enable) begin
                    state_nx_s = SCAN_D1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SCAN_D1, SCAN_D2: begin
                if (!bus.Enable) begin
                    state_nx_s = IDLE;
                    count_nx_s = '0;
                end else if (count_r == CNT_LAST) begin
                    state_nx_s = (state_r == SCAN_D1) ? SCAN_D2 : SCAN_D1;
                    count_nx_s = '0;
                end else begin
                    state_nx_s = state_r;
                    count_nx_s = count_r + CW'(1'b1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                count_nx_s = '0;
            end
        endcase
    end

    // Double-buffered patterns: active only changes at a frame start or in idle.
    always_comb begin
        if (bus.Load) begin
            pend_nx_s = load_pat_s;
        end else begin
            pend_nx_s = pend_r;
        end

        if ((state_r == IDLE) || frame_end_s) begin
            act_nx_s = bus.Load ? load_pat_s : pend_r;
        end else begin
            act_nx_s = act_r;
        end
    end

    // Display decode of the upcoming cycle, captured into the output flops.
    always_comb begin
        segments_nx_s   = 8'h00;
        digit_sel_nx_s  = 2'b00;
        frame_done_nx_s = (state_nx_s == SCAN_D2) && (count_nx_s == CNT_LAST);
        case (state_nx_s)
            SCAN_D1: begin
                if (in_window(count_nx_s, bus.Brightness) &&
                    !blank_digit1(act_nx_s[15:8], bus.BlankZero)) begin
                    segments_nx_s  = act_nx_s[15:8];
                    digit_sel_nx_s = 2'b01;
                end else begin
                    segments_nx_s  = 8'h00;
                    digit_sel_nx_s = 2'b00;
                end
            end
            SCAN_D2: begin
                if (in_window(count_nx_s, bus.Brightness)) begin
                    segments_nx_s  = act_nx_s[7:0];
                    digit_sel_nx_s = 2'b10;
                end else begin
                    segments_nx_s  = 8'h00;
                    digit_sel_nx_s = 2'b00;
                end
            end
            default: begin
                segments_nx_s  = 8'h00;
                digit_sel_nx_s = 2'b00;
            end
        endcase
    end

    // State, pattern and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= IDLE;
            count_r      <= '0;
            pend_r       <= 16'h0000;
            act_r        <= 16'h0000;
            segments_r   <= 8'h00;
            digit_sel_r  <= 2'b00;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            count_r      <= count_nx_s;
            pend_r       <= pend_nx_s;
            act_r        <= act_nx_s;
            segments_r   <= segments_nx_s;
            digit_sel_r  <= digit_sel_nx_s;
            frame_done_r <= frame_done_nx_s;
        end
    end

    assign bus.Segments  = segments_r;
    assign bus.DigitSel  = digit_sel_r;
    assign bus.FrameDone = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios followed by
// randomized stimulus, all compared against a position-based display model.
module tb_seven_seg_scanner;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scanner_if bus();

    seven_seg_scanner #(.TICK_DIV(T)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 'pos' is the cycle index within a 2*T frame.
    bit         m_scan = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_pend [2];
    logic [7:0] m_act  [2];
    logic [10:0] m_exp = 11'd0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int cnt, lim;
        logic [7:0] seg;
        logic [1:0] sel;
        if (rst) begin
            m_scan = 1'b0; m_pos = 0;
            m_pend[0] = 8'h00; m_pend[1] = 8'h00;
            m_act[0]  = 8'h00; m_act[1]  = 8'h00;
        end else begin
            if (!m_scan || (m_pos == 2*T-1)) begin
                if (bus.Load) begin
                    m_act[0] = bus.SevenSegDig1; m_act[1] = bus.SevenSegDig2;
                end else begin
                    m_act[0] = m_pend[0]; m_act[1] = m_pend[1];
                end
            end
            if (bus.Load) begin
                m_pend[0] = bus.SevenSegDig1; m_pend[1] = bus.SevenSegDig2;
            end
            if (!m_scan) begin
                m_scan = bus.Enable; m_pos = 0;
            end else if (!bus.Enable) begin
                m_scan = 1'b0; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % (2*T);
            end
        end
        seg = 8'h00; sel = 2'b00;
        cnt = m_pos % T;
        lim = (int'(bus.Brightness) + 1) * T / 8;
        if (m_scan && cnt < lim) begin
            if (m_pos < T) begin
                if (!(bus.BlankZero && m_act[0] == 8'h3F)) begin
                    seg = m_act[0]; sel = 2'b01;
                end
            end else begin
                seg = m_act[1]; sel = 2'b10;
            end
        end
        m_exp = {seg, sel, (m_scan && m_pos == 2*T-1)};
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_val(tag, {21'd0, bus.Segments, bus.DigitSel, bus.FrameDone},
                  {21'd0, m_exp});
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Advance until the model sits at the given frame position (bounded).
    task automatic run_until(input string tag, input int pos);
        int k;
        k = 0;
        while (!(m_scan && m_pos == pos) && k < 200) begin
            step(tag);
            k++;
        end
        if (k >= 200) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bus.SevenSegDig1 = 8'hFF; bus.SevenSegDig2 = 8'hFF;
        bus.Load = 1'b1; bus.Enable = 1'b1;
        bus.Brightness = 3'd7; bus.BlankZero = 1'b0;

        // Reset with Enable and Load asserted.
        rst = 1'b1;
        run("reset", 2);
        check_val("reset_out", {21'd0, bus.Segments, bus.DigitSel, bus.FrameDone}, 32'd0);
        rst = 1'b0; bus.Load = 1'b0; bus.Enable = 1'b0;
        run("post_reset", 1);
        check_val("post_reset_out", {21'd0, bus.Segments, bus.DigitSel, bus.FrameDone}, 32'd0);

        // Basic scan at full brightness.
        bus.SevenSegDig1 = 8'b0100_1111; bus.SevenSegDig2 = 8'b0101_1110;
        bus.Load = 1'b1;
        run("load_idle", 1);
        bus.Load = 1'b0; bus.Enable = 1'b1;
        run("basic_scan", 1);
        check_val("first_digit", {30'd0, bus.DigitSel}, 32'd1);
        run("basic_scan", 2*2*T - 1);

        // Dim setting.
        bus.Brightness = 3'd1;
        run("bright1", 2*T);
        bus.Brightness = 3'd7;

        // Mid-frame load at count 5 of digit 1.
        run_until("to_mid", 5);
        bus.SevenSegDig1 = 8'b0000_0110; bus.Load = 1'b1;
        run("mid_load", 1);
        bus.Load = 1'b0;
        run("mid_load_after", 3*T);

        // Leading-zero blanking.
        bus.SevenSegDig1 = 8'b0011_1111; bus.BlankZero = 1'b1; bus.Load = 1'b1;
        run("bz_load", 1);
        bus.Load = 1'b0;
        run("blank_zero", 3*2*T);

        // Enable drop at count 9 of digit 2, then restart.
        bus.BlankZero = 1'b0;
        run_until("to_drop", T + 9);
        bus.Enable = 1'b0;
        run("en_drop", 1);
        check_val("en_drop_out", {21'd0, bus.Segments, bus.DigitSel, bus.FrameDone}, 32'd0);
        run("idle", 3);
        bus.Enable = 1'b1;
        run("restart", 1);
        check_val("restart_sel", {30'd0, bus.DigitSel}, 32'd1);
        run("restart_run", 2*T);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            bus.Load   = ($urandom_range(0, 19) == 0);
            bus.Enable = ($urandom_range(0, 79) != 0);
            bus.SevenSegDig1 = ($urandom_range(0, 3) == 0) ? 8'h3F : 8'($urandom);
            bus.SevenSegDig2 = 8'($urandom);
            if ($urandom_range(0, 39) == 0) bus.Brightness = 3'($urandom);
            if ($urandom_range(0, 49) == 0) bus.BlankZero = ~bus.BlankZero;
            step("random");
            check_val("sel_not_11", {31'd0, &bus.DigitSel}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter: TICK_DIV, default 16, clocks per digit slot; SHALL be a multiple of 8 and at least 8.
REQ-002 Clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 SevenSegDig1  input  8  high-nibble digit pattern, bits {dp,g,f,e,d,c,b,a}, active-high.
REQ-005 SevenSegDig2  input  8  low-nibble digit pattern, same encoding.
REQ-006 Load  input  1  single-cycle strobe that captures both patterns.
REQ-007 Enable  input  1  scan enable; low blanks the display.
REQ-008 Brightness  input  3  duty level, where 0 is the dimmest and 7 is full on.
REQ-009 BlankZero  input  1  blanks digit 1 when its active pattern is 8'b00111111 ('0').
REQ-010 Segments  output  8  shared segment bus, active-high.
REQ-011 DigitSel  output  2  one-hot, active-high digit enable; bit0 drives digit 1 and bit1 drives digit 2.
REQ-012 FrameDone  output  1  one-cycle pulse at the end of each two-digit frame.

Function
REQ-013 The block SHALL hold two 16-bit pattern register sets: Pending, written by Load, and Active, which drives the display.
REQ-014 FSM states SHALL be IDLE, SCAN_D1 and SCAN_D2, with a prescaler Count from 0 to TICK_DIV-1.
REQ-015 In IDLE, Enable=1 SHALL move the FSM to SCAN_D1 with Count=0 on the next edge.
REQ-016 In SCAN_Dx, Count SHALL increment every cycle.
REQ-017 When Count=TICK_DIV-1, Count SHALL wrap to 0 and the FSM SHALL move SCAN_D1->SCAN_D2 or SCAN_D2->SCAN_D1.
REQ-018 Frame boundary = the cycle with SCAN_D2 and Count=TICK_DIV-1; FrameDone SHALL be 1 in exactly that cycle.
REQ-019 Enable=0 in any SCAN state SHALL move the FSM to IDLE with Count=0 on the next edge, with no FrameDone.
REQ-020 Load=1 SHALL capture both input patterns into Pending on that edge.
REQ-021 Pending SHALL transfer to Active at the edge ending the frame boundary cycle, and on any edge while in IDLE.
REQ-022 Load coinciding with a frame boundary, or occurring in IDLE, SHALL write the input patterns directly into Active.
REQ-023 Display changes SHALL therefore take effect only at frame start; there SHALL be no tearing within a frame.
REQ-024 On-window: the digit is lit while Count < (Brightness+1)*TICK_DIV/8.
REQ-025 With Brightness=7, the digit SHALL be lit for the whole slot.
REQ-026 SCAN_D1 inside its on-window SHALL give DigitSel=01 and Segments=Active Dig1.
REQ-027 SCAN_D1 SHALL instead give DigitSel=00 and Segments=0 when BlankZero=1 and Active Dig1=8'b00111111.
REQ-028 SCAN_D2 inside its on-window SHALL give DigitSel=10 and Segments=Active Dig2; BlankZero SHALL NOT affect digit 2.
REQ-029 Outside the on-window and in IDLE, Segments SHALL be 0 and DigitSel SHALL be 00.
REQ-030 DigitSel SHALL never be 11.
REQ-031 Outputs SHALL decode only from registered state, Count, Active, Brightness and BlankZero, with no combinational path from the pattern inputs.
REQ-032 Brightness and BlankZero SHALL be sampled live; a mid-slot change SHALL affect the window from the next cycle.

Reset
REQ-033 Rst=1 SHALL force IDLE, Count=0, Pending=0 and Active=0 on the next edge.
REQ-034 While Rst=1 and on the cycle after reset, Segments SHALL be 0, DigitSel 00 and FrameDone 0.
REQ-035 Rst SHALL take priority over Load and Enable.
REQ-036 Reset asserted mid-frame SHALL abort the scan; the next scan after release SHALL start at SCAN_D1 with Count=0.

Verification
REQ-037 Reset scenario: Rst=1 for 2 cycles with Enable=1 and Load=1 -> Segments=00000000, DigitSel=00, FrameDone=0 throughout and 1 cycle after release.
REQ-038 Basic scan scenario: TICK_DIV=16, Load Dig1=01001111 and Dig2=01011110, then Enable=1 and Brightness=7.
REQ-039 Basic scan response: 16 cycles of DigitSel=01/Segments=01001111, then 16 cycles of DigitSel=10/Segments=01011110, with FrameDone high on the 32nd cycle only; the pattern repeats.
REQ-040 Brightness scenario: Brightness=1 -> each 16-cycle slot is lit for Count 0..3 and dark for Count 4..15.
REQ-041 Mid-frame load scenario: Load Dig1=00000110 at Count=5 of SCAN_D1 -> the current frame still shows 01001111; the next frame shows 00000110.
REQ-042 Zero blanking scenario: BlankZero=1 with Active Dig1=00111111 -> DigitSel=00 for the whole D1 slot; the D2 slot is unchanged.
REQ-043 Enable drop scenario: Enable=0 at Count=9 of SCAN_D2 -> outputs are 0 next cycle with no FrameDone; re-enabling restarts at SCAN_D1 Count=0.
